repeated_sub_divider: RTL and testbench
=======================================

REPEATED_SUB_DIVIDER -- requirements
Module: repeated_sub_divider

Interface
REQ-001 The block SHALL have exactly one parameter: WIDTH, default 16, the width of the operand bus and all arithmetic registers.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division; it is level-sampled.
REQ-005 The block SHALL have port data_in, input, WIDTH bits: a shared operand bus carrying the dividend, then the divisor, on consecutive cycles.
REQ-006 The block SHALL have port quotient, output, WIDTH bits: the registered quotient register Q.
REQ-007 The block SHALL have port remainder, output, WIDTH bits: the registered working dividend A, which holds the final remainder when done is high.
REQ-008 The block SHALL have port busy, output, 1 bit: high in states LDA, LDB and SUB.
REQ-009 The block SHALL have port done, output, 1 bit: high only in state DONE.
REQ-010 The block SHALL have port div_err, output, 1 bit: high in DONE when the divisor was 0.

Function
REQ-011 The block SHALL be split into a datapath (registers A, B, Q; comparator A>=B; B==0 detect; subtractor; incrementer) and an FSM controller.
- The controller SHALL drive these datapath signals: LdA, LdB, ClrQ, SubA, IncQ.
REQ-012 The FSM SHALL have the states IDLE, LDA, LDB, SUB and DONE, encoded in 3 bits.
REQ-013 IDLE: if start=1 at a rising edge, the next state SHALL be LDA; otherwise the FSM SHALL stay in IDLE.
REQ-014 LDA: at the edge, A SHALL load data_in (the dividend); the next state SHALL be LDB.
REQ-015 LDB: at the edge, B SHALL load data_in (the divisor) and Q SHALL clear to 0; the next state SHALL be SUB.
REQ-016 SUB, B==0: the FSM SHALL go to DONE with Q set to all-ones, A unchanged and div_err set to 1.
REQ-017 SUB, B!=0 and A>=B: A SHALL update to A-B and Q to Q+1, and the FSM SHALL stay in SUB.
REQ-018 SUB, B!=0 and A<B: the FSM SHALL go to DONE with A and Q unchanged and div_err at 0.
REQ-019 DONE: the FSM SHALL stay in DONE while start=1 and go to IDLE when start=0; A, Q and div_err SHALL hold their values in DONE.
REQ-020 Leaving IDLE SHALL clear div_err to 0.
REQ-021 Arithmetic SHALL be unsigned, WIDTH bits, with no wrap-around; the subtraction SHALL occur only when A>=B.
REQ-022 Latency: done SHALL go high on the (Q+3)th rising edge after the edge that sampled start.
- Divide-by-zero latency SHALL be 3 edges.
- The worst case is all-ones/1, taking 2^WIDTH+2 edges.
REQ-023 A dividend smaller than the divisor (including a dividend of 0) SHALL produce quotient 0 and remainder equal to the dividend, with latency 3.
REQ-024 In any state other than IDLE and DONE, the value of start SHALL be ignored.
REQ-025 data_in SHALL be sampled only in LDA and LDB.
REQ-026 busy and done SHALL never be high together.

Reset
REQ-027 When rst=1, the state SHALL become IDLE immediately and asynchronously; A, B and Q SHALL clear to 0; and busy, done and div_err SHALL clear to 0.
REQ-028 rst asserted in the middle of a division SHALL abort the division with no residual state.
- After rst falls, a new start SHALL run a full, correct division.
REQ-029 If rst and a clock edge coincide, reset SHALL win.

Verification
REQ-030 Scenario 1: start=1 held; data_in=17 during LDA, then 5 during LDB.
- Required: done=1 on the 6th edge after start is sampled, quotient=3, remainder=2, div_err=0.
REQ-031 Scenario 2: dividend 5, divisor 17.
- Required: done after 3 edges, quotient=0, remainder=5.
REQ-032 Scenario 3: dividend 100, divisor 0.
- Required: done after 3 edges, div_err=1, quotient=16'hFFFF, remainder=100.
REQ-033 Scenario 4: dividend 40, divisor 4; rst pulsed high during SUB after 2 subtractions.
- Required: all outputs are 0 immediately, with no clock edge needed.
- Then a re-run with dividend 40, divisor 4 SHALL give quotient=10, remainder=0.
REQ-034 Scenario 5: a completed division, then start dropped for 1 cycle, then raised again with new operands 9 and 3.
- Required: DONE goes to IDLE, then a new run gives quotient=3, remainder=0, div_err=0.
REQ-035 Scenario 6 (all cases): a scoreboard SHALL check quotient*divisor+remainder==dividend and remainder<divisor at every rising edge of done.

Source files
------------

// File: rtl/repeated_sub_divider.sv
// Unsigned divider by repeated subtraction.
// Operands arrive on one shared bus: the dividend one cycle, then the divisor
// on the next. The controller then subtracts B from A once per cycle,
// counting the subtractions in Q, until A < B.
//
// Handshake: start is level-sampled in IDLE and DONE only. After it is seen
// in IDLE the block is busy while it loads and subtracts. It then sits in
// DONE (done=1, results stable) for as long as start stays high. Dropping
// start returns it to IDLE; raising it again begins a new division.
module repeated_sub_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_err,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, q_q;
  logic             err_q;

  // Datapath status and arithmetic results
  logic             a_ge_b;
  logic             b_zero;
  logic [WIDTH-1:0] a_diff;
  logic [WIDTH-1:0] q_inc;

  // Controller strobes into the datapath
  logic ld_a, ld_b, clr_q, sub_a, inc_q, set_q_ones, set_err, clr_err;

  // Comparator, zero detect, subtractor and incrementer
  always_comb begin
    a_ge_b = (a_q >= b_q);
    b_zero = (b_q == '0);
    a_diff = a_q - b_q;
    q_inc  = q_q + WIDTH'(1);
  end

  // State register; reset forces IDLE immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobe decode
  always_comb begin
    state_d    = state_q;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    clr_q      = 1'b0;
    sub_a      = 1'b0;
    inc_q      = 1'b0;
    set_q_ones = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LDA;
          clr_err = 1'b1;
        end
      end
      LDA: begin
        ld_a    = 1'b1;
        state_d = LDB;
      end
      LDB: begin
        ld_b    = 1'b1;
        clr_q   = 1'b1;
        state_d = SUB;
      end
      SUB: begin
        if (b_zero) begin
          // Divide by zero: saturate the quotient and flag it, A untouched
          set_q_ones = 1'b1;
          set_err    = 1'b1;
          state_d    = DONE;
        end else if (a_ge_b) begin
          sub_a = 1'b1;
          inc_q = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Working dividend: loaded from the bus, then reduced by B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
    end else if (ld_a) begin
      a_q <= data_in;
    end else if (sub_a) begin
      a_q <= a_diff;
    end
  end

  // Divisor register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q <= '0;
    end else if (ld_b) begin
      b_q <= data_in;
    end
  end

  // Quotient counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (clr_q) begin
      q_q <= '0;
    end else if (set_q_ones) begin
      q_q <= '1;
    end else if (inc_q) begin
      q_q <= q_inc;
    end
  end

  // Divide-by-zero flag, cleared when a new division starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (clr_err) begin
      err_q <= 1'b0;
    end else if (set_err) begin
      err_q <= 1'b1;
    end
  end

  // Outputs are decoded from registered state only
  always_comb begin
    quotient  = q_q;
    remainder = a_q;
    busy      = (state_q == LDA) || (state_q == LDB) || (state_q == SUB);
    done      = (state_q == DONE);
    div_err   = err_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_repeated_sub_divider.sv
// Bench for repeated_sub_divider: a hand-computed vector table,
// hand-written reset/restart sequences, and random operands checked
// against plain integer division.
module tb_repeated_sub_divider;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_err;
  logic [2:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  // Operands of each division in flight, packed {dividend, divisor}
  logic [2*W-1:0] exp_q[$];

  repeated_sub_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_err   (div_err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference results from ordinary integer division
  function automatic void ref_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic err, output int lat);
    if (dvs == 0) begin
      q   = {W{1'b1}};
      r   = dvd;
      err = 1'b1;
      lat = 3;
    end else begin
      q   = dvd / dvs;
      r   = dvd % dvs;
      err = 1'b0;
      lat = int'(dvd / dvs) + 3;
    end
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // Runs one division with start held high (or randomised while busy when
  // noisy), measures edges from the start-sampling edge until done, then
  // drops start for one cycle so the block returns to IDLE.
  task automatic run_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input bit noisy, input int budget,
                         output logic [W-1:0] gq, output logic [W-1:0] gr,
                         output logic gerr, output int lat, output bit to);
    to  = 1'b0;
    lat = 0;
    exp_q.push_back({dvd, dvs});
    start   = 1'b1;
    data_in = dvd;
    @(posedge clk);
    #1;
    while (!to && !done) begin
      if (lat == 0) data_in = dvd;
      else if (lat == 1) data_in = dvs;
      else if (noisy) begin
        data_in = W'($urandom);
        start   = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      lat++;
      if (lat > budget) to = 1'b1;
    end
    gq   = quotient;
    gr   = remainder;
    gerr = div_err;
    if (to) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: actual=no done after %0d edges required=done (dvd=%0d dvs=%0d)",
               lat, dvd, dvs);
      pulse_reset();
    end else begin
      check("busy_low_in_done", {31'b0, busy}, 32'd0);
      start   = 1'b0;
      data_in = W'($urandom);
      @(posedge clk);
      #1;
      check("idle_done_low", {31'b0, done}, 32'd0);
      check("idle_busy_low", {31'b0, busy}, 32'd0);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic done_prev = 1'b0;

  // Checks every rising edge of done against the arithmetic identity
  always @(posedge clk) begin
    logic [2*W-1:0] ops;
    logic [W-1:0]   s_dvd, s_dvs;
    logic [2*W-1:0] prod;
    #1;
    checks++;
    if (busy && done) begin
      errors++;
      $display("FAIL busy_done_overlap: actual=busy=1 done=1 required=not both high");
    end
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: actual=done with empty queue required=no done");
      end else begin
        ops   = exp_q.pop_front();
        s_dvd = ops[2*W-1:W];
        s_dvs = ops[W-1:0];
        if (s_dvs == 0) begin
          check("sb_zero_err", {31'b0, div_err}, 32'd1);
          check("sb_zero_q", {16'b0, quotient}, 32'h0000_FFFF);
          check("sb_zero_r", {16'b0, remainder}, {16'b0, s_dvd});
        end else begin
          prod = {{W{1'b0}}, quotient} * {{W{1'b0}}, s_dvs} + {{W{1'b0}}, remainder};
          check("sb_identity", prod, {16'b0, s_dvd});
          check("sb_rem_lt_div", {31'b0, (remainder < s_dvs)}, 32'd1);
          check("sb_err_low", {31'b0, div_err}, 32'd0);
        end
      end
    end
    done_prev = done;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
    int           lat;
  } vec_t;

  vec_t tbl[10];

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] gq, gr, mq, mr, dvd, dvs, lo;
    logic         gerr, merr;
    int           lat, mlat;
    bit           to;

    tbl[0] = '{dvd: 16'd17,    dvs: 16'd5,     q: 16'd3,      r: 16'd2,   err: 1'b0, lat: 6};
    tbl[1] = '{dvd: 16'd5,     dvs: 16'd17,    q: 16'd0,      r: 16'd5,   err: 1'b0, lat: 3};
    tbl[2] = '{dvd: 16'd100,   dvs: 16'd0,     q: 16'hFFFF,   r: 16'd100, err: 1'b1, lat: 3};
    tbl[3] = '{dvd: 16'd0,     dvs: 16'd7,     q: 16'd0,      r: 16'd0,   err: 1'b0, lat: 3};
    tbl[4] = '{dvd: 16'd9,     dvs: 16'd3,     q: 16'd3,      r: 16'd0,   err: 1'b0, lat: 6};
    tbl[5] = '{dvd: 16'd40,    dvs: 16'd4,     q: 16'd10,     r: 16'd0,   err: 1'b0, lat: 13};
    tbl[6] = '{dvd: 16'd7,     dvs: 16'd7,     q: 16'd1,      r: 16'd0,   err: 1'b0, lat: 4};
    tbl[7] = '{dvd: 16'd0,     dvs: 16'd0,     q: 16'hFFFF,   r: 16'd0,   err: 1'b1, lat: 3};
    tbl[8] = '{dvd: 16'hFFFF,  dvs: 16'hFFFF,  q: 16'd1,      r: 16'd0,   err: 1'b0, lat: 4};
    tbl[9] = '{dvd: 16'd1000,  dvs: 16'd1,     q: 16'd1000,   r: 16'd0,   err: 1'b0, lat: 1003};

    // Reset state, observed before any clock edge
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    #1;
    check("rst_quotient", {16'b0, quotient}, 32'd0);
    check("rst_remainder", {16'b0, remainder}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_div_err", {31'b0, div_err}, 32'd0);
    check("rst_state", {29'b0, state_dbg}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Start held low: block stays idle
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_start", {31'b0, busy | done}, 32'd0);

    // Table of hand-computed divisions, run back to back so each one
    // follows a single idle cycle after the previous completion
    for (int i = 0; i < 10; i++) begin
      run_div(tbl[i].dvd, tbl[i].dvs, 1'b0, tbl[i].lat + 10, gq, gr, gerr, lat, to);
      if (!to) begin
        check($sformatf("tbl%0d_quotient", i), {16'b0, gq}, {16'b0, tbl[i].q});
        check($sformatf("tbl%0d_remainder", i), {16'b0, gr}, {16'b0, tbl[i].r});
        check($sformatf("tbl%0d_div_err", i), {31'b0, gerr}, {31'b0, tbl[i].err});
        check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      end
    end

    // Done holds while start stays high
    exp_q.push_back({16'd50, 16'd7});
    start   = 1'b1;
    data_in = 16'd50;
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_in = 16'd7;
    repeat (11) @(posedge clk);
    #1;
    check("hold_done_reached", {31'b0, done}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("hold_done_stays", {31'b0, done}, 32'd1);
    check("hold_quotient", {16'b0, quotient}, 32'd7);
    check("hold_remainder", {16'b0, remainder}, 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    check("hold_back_to_idle", {31'b0, done | busy}, 32'd0);

    // Reset in the middle of a division, after two subtractions
    start   = 1'b1;
    data_in = 16'd40;
    @(posedge clk); #1;   // start sampled
    @(posedge clk); #1;   // dividend loaded
    data_in = 16'd4;
    @(posedge clk); #1;   // divisor loaded
    @(posedge clk); #1;   // first subtraction
    @(posedge clk); #1;   // second subtraction
    check("abort_pre_quotient", {16'b0, quotient}, 32'd2);
    check("abort_pre_remainder", {16'b0, remainder}, 32'd32);
    check("abort_pre_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_quotient", {16'b0, quotient}, 32'd0);
    check("abort_remainder", {16'b0, remainder}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_div_err", {31'b0, div_err}, 32'd0);
    check("abort_state", {29'b0, state_dbg}, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    run_div(16'd40, 16'd4, 1'b0, 30, gq, gr, gerr, lat, to);
    if (!to) begin
      check("rerun_quotient", {16'b0, gq}, 32'd10);
      check("rerun_remainder", {16'b0, gr}, 32'd0);
      check("rerun_latency", lat, 13);
    end

    // Divide-by-zero flag from one run must clear on the next run
    run_div(16'd3, 16'd0, 1'b0, 20, gq, gr, gerr, lat, to);
    run_div(16'd9, 16'd3, 1'b0, 20, gq, gr, gerr, lat, to);
    if (!to) begin
      check("err_cleared", {31'b0, gerr}, 32'd0);
      check("after_err_quotient", {16'b0, gq}, 32'd3);
    end

    // Random operands; start and data_in are scrambled while busy
    for (int n = 0; n < 60; n++) begin
      dvd = W'($urandom_range(0, 65535));
      if ($urandom_range(0, 9) == 0) begin
        dvs = '0;
      end else begin
        lo  = W'(int'(dvd) / 256 + 1);
        dvs = W'($urandom_range(int'(lo), 65535));
      end
      ref_div(dvd, dvs, mq, mr, merr, mlat);
      run_div(dvd, dvs, 1'b1, mlat + 10, gq, gr, gerr, lat, to);
      if (!to) begin
        check("rnd_quotient", {16'b0, gq}, {16'b0, mq});
        check("rnd_remainder", {16'b0, gr}, {16'b0, mr});
        check("rnd_div_err", {31'b0, gerr}, {31'b0, merr});
        check("rnd_latency", lat, mlat);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    check("sb_queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
